// File: rtl/drone_cmd_pkg.sv
// Shared encodings for the gesture-driven drone power command path.
package drone_cmd_pkg;

    localparam logic [2:0] ON_CODE  = 3'd1;
    localparam logic [2:0] OFF_CODE = 3'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUAL     = 3'd1,
        FIRE     = 3'd2,
        LOCKOUT  = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    typedef enum logic {
        TGT_OFF = 1'b0,
        TGT_ON  = 1'b1
    } target_t;

endpackage

// File: rtl/frame_watchdog.sv
// Counts clocks since the last gesture frame; saturates at LIMIT and flags expiry.
module frame_watchdog #(
    parameter int LIMIT = 1_625_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (count_q != LIM)
            count_q <= count_q + 1'b1;
    end

    assign expired = (count_q == LIM);

endmodule

// File: rtl/gesture_on_off_cmd.sv
// Qualifies held gestures into single-cycle is_on / is_off power command pulses,
// with a post-fire lockout and a release requirement before the next command.
module gesture_on_off_cmd #(
    parameter int         HOLD_FRAMES    = 8,
    parameter int         LOCKOUT_FRAMES = 30,
    parameter int         TIMEOUT_CYCLES = 1_625_000,
    parameter logic [2:0] ON_CODE        = drone_cmd_pkg::ON_CODE,
    parameter logic [2:0] OFF_CODE       = drone_cmd_pkg::OFF_CODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       gesture_valid,
    input  logic [2:0] gesture_code,
    input  logic       on_off_s,
    output logic       is_on,
    output logic       is_off,
    output logic       busy
);
    import drone_cmd_pkg::*;

    localparam int CNT_MAX = (HOLD_FRAMES > LOCKOUT_FRAMES) ? HOLD_FRAMES : LOCKOUT_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_N = CW'(HOLD_FRAMES);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCKOUT_FRAMES);

    state_t        state_q, state_d;
    target_t       target_q, target_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] lock_q, lock_d;
    logic          is_on_q, is_off_q;
    logic          expired;
    logic [2:0]    tgt_code;
    logic          code_is_tgt;
    logic          state_match;

    frame_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (gesture_valid),
        .expired (expired)
    );

    assign tgt_code    = (target_q == TGT_ON) ? ON_CODE : OFF_CODE;
    assign code_is_tgt = (gesture_code == tgt_code);
    // Drone already in the state we were qualifying toward: nothing left to request.
    assign state_match = ((target_q == TGT_ON) == on_off_s);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        hold_d   = hold_q;
        lock_d   = lock_q;
        case (state_q)
            IDLE: begin
                if (gesture_valid) begin
                    if (gesture_code == OFF_CODE && on_off_s) begin
                        target_d = TGT_OFF;
                        hold_d   = CW'(1);
                        state_d  = (HOLD_FRAMES == 1) ? FIRE : QUAL;
                    end else if (gesture_code == ON_CODE && !on_off_s) begin
                        target_d = TGT_ON;
                        hold_d   = CW'(1);
                        state_d  = (HOLD_FRAMES == 1) ? FIRE : QUAL;
                    end
                end
            end
            QUAL: begin
                if (state_match || expired) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (gesture_valid) begin
                    if (code_is_tgt) begin
                        hold_d = hold_q + 1'b1;
                        if (hold_q == HOLD_N - 1'b1)
                            state_d = FIRE;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
            end
            FIRE: begin
                hold_d  = '0;
                lock_d  = '0;
                state_d = (LOCKOUT_FRAMES == 0) ? WAIT_REL : LOCKOUT;
            end
            LOCKOUT: begin
                if (lock_q == LOCK_N)
                    state_d = WAIT_REL;
                else if (gesture_valid)
                    lock_d = lock_q + 1'b1;
            end
            WAIT_REL: begin
                // The releasing frame only ends the wait; it does not start a new hold.
                if ((gesture_valid && !code_is_tgt) || expired)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
                lock_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= TGT_OFF;
            hold_q   <= '0;
            lock_q   <= '0;
            is_on_q  <= 1'b0;
            is_off_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            lock_q   <= lock_d;
            is_on_q  <= (state_q == FIRE) && (target_q == TGT_ON);
            is_off_q <= (state_q == FIRE) && (target_q == TGT_OFF);
        end
    end

    // Suppress a pending pulse during the cycle reset is asserted.
    assign is_on  = is_on_q  & ~reset;
    assign is_off = is_off_q & ~reset;
    assign busy   = (state_q == QUAL) || (state_q == LOCKOUT) || (state_q == WAIT_REL);

endmodule
